// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift on device clocks, ACK check.
// Optional PS2Clk deglitcher enabled by defining PS2_HOST_TX_FILTER_EN.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 1500000
`ifdef PS2_HOST_TX_FILTER_EN
    ,
    parameter int unsigned FILTER_LEN = 8
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       PS2Clk,
    input  logic       PS2Data,
    output logic       ps2_clk_low,
    output logic       ps2_data_low,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int unsigned IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE} state_t;

    state_t        state_q;
    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic          clk_prev_q;
    logic          clk_s;
    logic          data_s;
    logic          edge_src;
    logic          fe;
    logic [9:0]    shift_q;
    logic [3:0]    bit_cnt_q;
    logic [IW-1:0] inh_cnt_q;
    logic [TW-1:0] tmo_q;
    logic          tmo_last;
    logic          clk_low_q;
    logic          data_low_q;
    logic          done_q;
    logic          err_q;

    // Lines idle high, so synchronisers reset to 1 to avoid a false edge out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], PS2Clk};
            data_sync_q <= {data_sync_q[0], PS2Data};
        end
    end

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

`ifdef PS2_HOST_TX_FILTER_EN
    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          filt_q;
    logic [FW-1:0] filt_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else if (clk_s == filt_q) begin
            filt_cnt_q <= '0;
        end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
            filt_q     <= clk_s;
            filt_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
        end
    end

    assign edge_src = filt_q;
`else
    assign edge_src = clk_s;
`endif

    always_ff @(posedge clk) begin
        if (reset) clk_prev_q <= 1'b1;
        else       clk_prev_q <= edge_src;
    end

    assign fe       = clk_prev_q & ~edge_src;
    assign tmo_last = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            inh_cnt_q  <= '0;
            tmo_q      <= '0;
            clk_low_q  <= 1'b0;
            data_low_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    clk_low_q  <= 1'b0;
                    data_low_q <= 1'b0;
                    if (tx_valid) begin
                        shift_q   <= {1'b1, ~^tx_data, tx_data};
                        inh_cnt_q <= '0;
                        clk_low_q <= 1'b1;
                        state_q   <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inh_cnt_q == IW'(INHIBIT_CYCLES - 1)) begin
                        data_low_q <= 1'b1;
                        state_q    <= REQ;
                    end else begin
                        inh_cnt_q <= inh_cnt_q + 1'b1;
                    end
                end
                REQ: begin
                    clk_low_q <= 1'b0;
                    bit_cnt_q <= '0;
                    tmo_q     <= '0;
                    state_q   <= SHIFT;
                end
                SHIFT: begin
                    if (fe) begin
                        // Stop bit is shift_q[9]=1, so the last edge releases data.
                        data_low_q <= ~shift_q[bit_cnt_q];
                        bit_cnt_q  <= bit_cnt_q + 4'd1;
                        tmo_q      <= '0;
                        if (bit_cnt_q == 4'd9) state_q <= ACK;
                    end else if (tmo_last) begin
                        clk_low_q  <= 1'b0;
                        data_low_q <= 1'b0;
                        err_q      <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ACK: begin
                    if (fe) begin
                        tmo_q <= '0;
                        if (!data_s) begin
                            state_q <= WAIT_IDLE;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else if (tmo_last) begin
                        clk_low_q  <= 1'b0;
                        data_low_q <= 1'b0;
                        err_q      <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (clk_s && data_s) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (tmo_last) begin
                        clk_low_q  <= 1'b0;
                        data_low_q <= 1'b0;
                        err_q      <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: begin
                    clk_low_q  <= 1'b0;
                    data_low_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready     = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign ps2_clk_low  = clk_low_q;
    assign ps2_data_low = data_low_q;
    assign tx_done      = done_q;
    assign tx_error     = err_q;

endmodule
